sprite_mem_loader: RTL

SPRITE_MEM_LOADER -- requirements
Module: sprite_mem_loader

---
 rtl/sprite_mem_loader_pkg.sv | 16 +
 rtl/xor_checksum.sv | 36 +++
 rtl/sprite_mem_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_mem_loader_pkg.sv
// Shared constants and state encoding for the sprite memory loader.
package sprite_mem_loader_pkg;

    localparam int DEFAULT_DEPTH      = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CHECKSUM_WIDTH     = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/xor_checksum.sv
// Byte-wise XOR accumulator with synchronous clear; clear wins over enable.
module xor_checksum
    import sprite_mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     byte_in,
    output logic [CHECKSUM_WIDTH-1:0] acc
);

    logic [CHECKSUM_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q ^ CHECKSUM_WIDTH'(byte_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sprite_mem_loader.sv
// Streams DEPTH bytes into sprite memory, optionally reads them back and compares XOR checksums.
// Readback verification is built only when SPRITE_MEM_LOADER_VERIFY_EN is defined.
module sprite_mem_loader
    import sprite_mem_loader_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic                  i_Byte_Valid,
    input  logic [DATA_WIDTH-1:0] i_Byte_Data,
    output logic                  o_Byte_Ready,
    output logic                  o_write_en,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_read_en,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        hs_cnt_q, hs_cnt_d;
    logic                    ready_q, ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    handshake;
    logic                    start_load;
    logic [CHECKSUM_WIDTH-1:0] load_sum;
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [CHECKSUM_WIDTH-1:0] rb_sum, rb_sum_next;
`endif

    assign handshake  = i_Byte_Valid && ready_q;
    assign start_load = i_Start && (state_q == ST_IDLE || state_q == ST_DONE);

    xor_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_load_sum (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .clear   (start_load),
        .enable  (handshake),
        .byte_in (i_Byte_Data),
        .acc     (load_sum)
    );

`ifdef SPRITE_MEM_LOADER_VERIFY_EN
    xor_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_readback_sum (
        .clk     (i_Clk),
        .rst     (i_Reset),
        .clear   (start_load),
        .enable  (rd_valid_q && state_q == ST_VERIFY),
        .byte_in (i_read_data),
        .acc     (rb_sum)
    );
    assign rb_sum_next = rb_sum ^ CHECKSUM_WIDTH'(i_read_data);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hs_cnt_d  = hs_cnt_q;
        ready_d   = ready_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        error_d   = error_q;
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = rd_en_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_Start) begin
                    state_d  = ST_LOAD;
                    addr_d   = '0;
                    hs_cnt_d = '0;
                    ready_d  = 1'b1;
                    error_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = i_Byte_Data;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    hs_cnt_d  = hs_cnt_q + CNT_W'(1);
                    if (hs_cnt_q == LAST_IDX) begin
                        ready_d = 1'b0;
                    end
                end else if (!ready_q) begin
                    // One drain cycle lets the final write strobe out before leaving LOAD.
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
                    state_d  = ST_VERIFY;
                    rd_cnt_d = '0;
`else
                    state_d  = ST_DONE;
`endif
                end
            end
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (rd_cnt_q != DEPTH_CNT) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_WIDTH'(rd_cnt_q);
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                end else if (rd_valid_q && !rd_en_q) begin
                    error_d = (load_sum != rb_sum_next);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            hs_cnt_q  <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hs_cnt_q  <= hs_cnt_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef SPRITE_MEM_LOADER_VERIFY_EN
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
`endif
        end
    end

    assign o_Byte_Ready = ready_q;
    assign o_write_en   = wr_en_q;
    assign o_write_addr = wr_addr_q;
    assign o_write_data = wr_data_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Error      = error_q;

`ifdef SPRITE_MEM_LOADER_VERIFY_EN
    assign o_read_en   = rd_en_q;
    assign o_read_addr = rd_addr_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_read_data, load_sum};
    assign o_read_en     = 1'b0;
    assign o_read_addr   = '0;
`endif

endmodule
